// File: rtl/framed_serial_tx.sv
// rtl/framed_serial_tx.sv - serial frame transmitter: "101" preamble, MSB-first payload, even parity, idle gap
module framed_serial_tx #(
    parameter int WIDTH   = 8,
    parameter int GAP_LEN = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             tx,
    output logic             tx_valid,
    output logic             busy,
    output logic             frame_done
);

    // One counter serves PRE, DATA and GAP, so it is sized for the longest of the three.
    localparam int CNT_M1  = (WIDTH > 3) ? WIDTH : 3;
    localparam int CNT_MAX = (GAP_LEN > CNT_M1) ? GAP_LEN : CNT_M1;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(2);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        DATA = 3'd2,
        PAR  = 3'd3,
        GAP  = 3'd4
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shift_q;
    logic             parity_q;
    logic [CNT_W-1:0] cnt_q;
    logic             tx_q;
    logic             tx_valid_q;
    logic             busy_q;
    logic             frame_done_q;

    assign in_ready   = (state_q == IDLE) && !rst;
    assign tx         = tx_q;
    assign tx_valid   = tx_valid_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

    // Outputs are registered against the state being entered, so the first
    // preamble bit appears in the cycle right after acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            cnt_q        <= '0;
            tx_q         <= 1'b0;
            tx_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tx_q       <= 1'b0;
                    tx_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                    if (in_valid) begin
                        shift_q    <= in_data;
                        parity_q   <= ^in_data;
                        state_q    <= PRE;
                        cnt_q      <= '0;
                        tx_q       <= 1'b1;
                        tx_valid_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                PRE: begin
                    if (cnt_q == PRE_LAST) begin
                        state_q <= DATA;
                        cnt_q   <= '0;
                        tx_q    <= shift_q[WIDTH-1];
                        shift_q <= shift_q << 1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                        tx_q  <= cnt_q[0];
                    end
                end
                DATA: begin
                    if (cnt_q == DATA_LAST) begin
                        state_q <= PAR;
                        cnt_q   <= '0;
                        tx_q    <= parity_q;
                    end else begin
                        cnt_q   <= cnt_q + CNT_ONE;
                        tx_q    <= shift_q[WIDTH-1];
                        shift_q <= shift_q << 1;
                    end
                end
                PAR: begin
                    state_q    <= GAP;
                    cnt_q      <= '0;
                    tx_q       <= 1'b0;
                    tx_valid_q <= 1'b0;
                end
                GAP: begin
                    tx_q       <= 1'b0;
                    tx_valid_q <= 1'b0;
                    if (cnt_q == GAP_LAST) begin
                        state_q      <= IDLE;
                        cnt_q        <= '0;
                        busy_q       <= 1'b0;
                        frame_done_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    cnt_q      <= '0;
                    tx_q       <= 1'b0;
                    tx_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_framed_serial_tx.sv
// tb/tb_framed_serial_tx.sv - directed self-checking bench for framed_serial_tx
module tb_framed_serial_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready, tx, tx_valid, busy, frame_done;

    logic       v4;
    logic [3:0] d4;
    logic       rdy4, tx4, txv4, busy4, done4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    framed_serial_tx #(.WIDTH(8), .GAP_LEN(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .tx(tx), .tx_valid(tx_valid), .busy(busy),
        .frame_done(frame_done)
    );

    framed_serial_tx #(.WIDTH(4), .GAP_LEN(1)) dut4 (
        .clk(clk), .rst(rst), .in_valid(v4), .in_data(d4),
        .in_ready(rdy4), .tx(tx4), .tx_valid(txv4), .busy(busy4),
        .frame_done(done4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode 0: drop in_valid after acceptance; 1: keep it high; 2: push toggling
    // data during DATA, then present 8'h3C from the first IDLE cycle.
    task automatic frame8(input string name, input logic [7:0] w, input logic [11:0] bits, input int mode);
        in_data  = w;
        in_valid = 1'b1;
        step();
        if (mode == 0) in_valid = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            if (c <= 12) begin
                check({name, " tx"}, tx, bits[12-c]);
                check({name, " tx_valid"}, tx_valid, 1'b1);
            end else begin
                check({name, " gap tx"}, tx, 1'b0);
                check({name, " gap tx_valid"}, tx_valid, 1'b0);
            end
            check({name, " busy"}, busy, 1'b1);
            check({name, " frame_done"}, frame_done, 1'b0);
            check({name, " in_ready"}, in_ready, 1'b0);
            if (mode == 2 && c >= 3) begin
                in_valid = 1'b1;
                in_data  = c[0] ? 8'h5A : 8'hA5;
            end
            step();
        end
        check({name, " done"}, frame_done, 1'b1);
        check({name, " done busy"}, busy, 1'b0);
        check({name, " done in_ready"}, in_ready, 1'b1);
        check({name, " done tx_valid"}, tx_valid, 1'b0);
        if (mode == 2) in_data = 8'h3C;
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h00;
        v4       = 1'b0;
        d4       = 4'h0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst in_ready", in_ready, 1'b0);
            check("rst tx", tx, 1'b0);
            check("rst tx_valid", tx_valid, 1'b0);
            check("rst busy", busy, 1'b0);
            check("rst frame_done", frame_done, 1'b0);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("post-rst in_ready", in_ready, 1'b1);
        step();
        check("idle tx", tx, 1'b0);
        check("idle busy", busy, 1'b0);

        frame8("A5", 8'hA5, 12'b101_10100101_0, 0);
        step();
        check("A5 done falls", frame_done, 1'b0);

        frame8("01", 8'h01, 12'b101_00000001_1, 1);
        frame8("FF", 8'hFF, 12'b101_11111111_0, 0);
        step();
        check("FF done falls", frame_done, 1'b0);

        frame8("00", 8'h00, 12'b101_00000000_0, 2);
        frame8("3C", 8'h3C, 12'b101_00111100_0, 0);
        step();

        in_data  = 8'hC3;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            if (c < 7) step();
        end
        check("C3 4th data bit", tx, 1'b0);
        check("C3 busy", busy, 1'b1);
        rst = 1'b1;
        step();
        check("abort tx", tx, 1'b0);
        check("abort tx_valid", tx_valid, 1'b0);
        check("abort busy", busy, 1'b0);
        check("abort frame_done", frame_done, 1'b0);
        rst = 1'b0;
        #1;
        check("abort in_ready", in_ready, 1'b1);
        for (int c = 0; c < 16; c++) begin
            step();
            check("abort no done", frame_done, 1'b0);
            check("abort no resume", tx_valid, 1'b0);
        end
        frame8("81", 8'h81, 12'b101_10000001_0, 0);
        step();

        d4 = 4'b0111;
        v4 = 1'b1;
        for (int f = 0; f < 2; f++) begin
            step();
            if (f == 1) v4 = 1'b0;
            for (int c = 1; c <= 10; c++) begin
                if (c <= 8) begin
                    check("w4 tx", tx4, (c == 2 || c == 4) ? 1'b0 : 1'b1);
                    check("w4 tx_valid", txv4, 1'b1);
                end else if (c == 9) begin
                    check("w4 gap tx", tx4, 1'b0);
                    check("w4 gap tx_valid", txv4, 1'b0);
                    check("w4 gap busy", busy4, 1'b1);
                end else begin
                    check("w4 done", done4, 1'b1);
                    check("w4 done busy", busy4, 1'b0);
                end
                if (c < 10) step();
            end
        end
        step();
        check("w4 done falls", done4, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
